ex_operand_stage: RTL

- Decode-to-execute pipeline register with execute-stage operand resolution.
- Latches decode outputs into EX, then applies the forward selects produced by the RAW hazard forwarder to give final ALU operands src_a_e/src_b_e.
- While EX is stalled, tracks forwarded values cycle by cycle, so operands are not lost as producers drain past writeback.
- Also supplies rs1_e/rs2_e, which feed back into the forwarder.

---
 rtl/riscv_defines.sv | 19 +
 rtl/operand_fwd_mux.sv | 58 +++++
 rtl/ex_operand_stage.sv | 109 ++++++++++
 3 files changed

// File: rtl/riscv_defines.sv
// Shared core definitions: datapath width, forwarding selects, memory access kinds.
package riscv_defines;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    FWD_EX   = 2'd0,
    FWD_MEM1 = 2'd1,
    FWD_MEM2 = 2'd2,
    FWD_WB   = 2'd3
  } forward_e_t;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_READ  = 2'd1,
    MEM_WRITE = 2'd2
  } memaccess_t;

endpackage

// File: rtl/operand_fwd_mux.sv
// One EX operand: capture with optional writeback bypass, hold register,
// and the forward-select mux that produces the final ALU operand.
module operand_fwd_mux
  import riscv_defines::*;
#(
  parameter int unsigned XLEN      = riscv_defines::XLEN,
  parameter bit          WB_BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush_e,
  input  logic            stall_e,
  input  logic [4:0]      rs_d,
  input  logic [XLEN-1:0] rd_data_d,
  input  logic            regwrite_w,
  input  logic [4:0]      rd_w,
  input  logic [XLEN-1:0] result_w,
  input  forward_e_t      fwd_sel,
  input  logic [XLEN-1:0] aluresult_m1,
  input  logic [XLEN-1:0] aluresult_m2,
  output logic [XLEN-1:0] src
);

  logic [XLEN-1:0] op_q;
  logic [XLEN-1:0] cap;

  // Capture value: a same-cycle writeback to the source register wins over the regfile read.
  always_comb begin
    cap = rd_data_d;
    if (WB_BYPASS && regwrite_w && (rd_w != '0) && (rd_w == rs_d))
      cap = result_w;
  end

  // Final operand selected by the forwarder.
  always_comb begin
    src = op_q;
    case (fwd_sel)
      FWD_EX:   src = op_q;
      FWD_MEM1: src = aluresult_m1;
      FWD_MEM2: src = aluresult_m2;
      FWD_WB:   src = result_w;
      default:  src = op_q;
    endcase
  end

  // Hold register: flush holds, stall tracks the forwarded value, otherwise capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      op_q <= '0;
    else if (flush_e)
      op_q <= op_q;
    else if (stall_e)
      op_q <= src;
    else
      op_q <= cap;
  end

endmodule

// File: rtl/ex_operand_stage.sv
// Decode-to-execute pipeline register with forwarded operand resolution.
module ex_operand_stage
  import riscv_defines::*;
#(
  parameter int unsigned XLEN      = riscv_defines::XLEN,
  parameter bit          WB_BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_e,
  input  logic            flush_e,
  input  logic            valid_d,
  input  logic [XLEN-1:0] pc_d,
  input  logic [XLEN-1:0] imm_d,
  input  logic [4:0]      rs1_d,
  input  logic [4:0]      rs2_d,
  input  logic [4:0]      rd_d,
  input  logic [XLEN-1:0] rd1_d,
  input  logic [XLEN-1:0] rd2_d,
  input  logic            regwrite_d,
  input  memaccess_t      memaccess_d,
  input  forward_e_t      forwarda_e,
  input  forward_e_t      forwardb_e,
  input  logic [XLEN-1:0] aluresult_m1,
  input  logic [XLEN-1:0] aluresult_m2,
  input  logic [XLEN-1:0] result_w,
  input  logic            regwrite_w,
  input  logic [4:0]      rd_w,
  output logic            valid_e,
  output logic            regwrite_e,
  output logic [4:0]      rs1_e,
  output logic [4:0]      rs2_e,
  output logic [4:0]      rd_e,
  output memaccess_t      memaccess_e,
  output logic [XLEN-1:0] pc_e,
  output logic [XLEN-1:0] imm_e,
  output logic [XLEN-1:0] src_a_e,
  output logic [XLEN-1:0] src_b_e
);

  // EX control/index register: flush inserts a bubble, stall holds, otherwise load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_e     <= 1'b0;
      regwrite_e  <= 1'b0;
      memaccess_e <= MEM_NONE;
      rs1_e       <= '0;
      rs2_e       <= '0;
      rd_e        <= '0;
      pc_e        <= '0;
      imm_e       <= '0;
    end else if (flush_e) begin
      valid_e     <= 1'b0;
      regwrite_e  <= 1'b0;
      memaccess_e <= MEM_NONE;
      rs1_e       <= '0;
      rs2_e       <= '0;
      rd_e        <= '0;
    end else if (!stall_e) begin
      valid_e     <= valid_d;
      regwrite_e  <= regwrite_d;
      memaccess_e <= memaccess_d;
      rs1_e       <= rs1_d;
      rs2_e       <= rs2_d;
      rd_e        <= rd_d;
      pc_e        <= pc_d;
      imm_e       <= imm_d;
    end
  end

  operand_fwd_mux #(
    .XLEN      (XLEN),
    .WB_BYPASS (WB_BYPASS)
  ) u_op_a (
    .clk          (clk),
    .reset        (reset),
    .flush_e      (flush_e),
    .stall_e      (stall_e),
    .rs_d         (rs1_d),
    .rd_data_d    (rd1_d),
    .regwrite_w   (regwrite_w),
    .rd_w         (rd_w),
    .result_w     (result_w),
    .fwd_sel      (forwarda_e),
    .aluresult_m1 (aluresult_m1),
    .aluresult_m2 (aluresult_m2),
    .src          (src_a_e)
  );

  operand_fwd_mux #(
    .XLEN      (XLEN),
    .WB_BYPASS (WB_BYPASS)
  ) u_op_b (
    .clk          (clk),
    .reset        (reset),
    .flush_e      (flush_e),
    .stall_e      (stall_e),
    .rs_d         (rs2_d),
    .rd_data_d    (rd2_d),
    .regwrite_w   (regwrite_w),
    .rd_w         (rd_w),
    .result_w     (result_w),
    .fwd_sel      (forwardb_e),
    .aluresult_m1 (aluresult_m1),
    .aluresult_m2 (aluresult_m2),
    .src          (src_b_e)
  );

endmodule
